keccak_digest_reader: RTL and testbench

Return-path companion to the CPU-side Keccak input feeder. It captures the digest from the Keccak core when that core pulses its done strobe. It then streams the digest back to the CPU as 32-bit words under a valid/read handshake. The number of words streamed is set by the selected hash length. It sits between keccak_ctrl's digest output and the or1200 custom-instruction result path.

---
 rtl/keccak_digest_reader.sv | 110 +++++++++++
 tb/tb_keccak_digest_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keccak_digest_reader.sv
// keccak_digest_reader: captures the Keccak digest on the core's done strobe
// and returns it to the CPU as WORD_W-bit words under a valid/read handshake.
// The hash_num input sets how many words are returned.
// Optional build macro KECCAK_BYTESWAP_EN: byte-reverses each returned word so
// that the little-endian Keccak lane order matches the big-endian or1200 view.
module keccak_digest_reader #(
  parameter  int DIGEST_W = 512,
  parameter  int WORD_W   = 32,
  localparam int NWORDS   = DIGEST_W / WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          hash_num,
  input  logic [DIGEST_W-1:0] digest_in,
  input  logic                digest_valid,
  output logic                digest_busy,
  output logic [WORD_W-1:0]   hash_out32,
  output logic                out_valid,
  output logic                out_last,
  input  logic                rd_en,
  input  logic                flush,
  output logic                overflow
);

  localparam int CNT_W = $clog2(NWORDS + 1);
  localparam int NBYTE = WORD_W / 8;

  localparam logic IDLE  = 1'b0;
  localparam logic SERVE = 1'b1;

  logic                st, st_n;
  logic [DIGEST_W-1:0] sr, sr_n;
  logic [CNT_W-1:0]    cnt, cnt_n, len;
  logic                ovf_n;
  logic [WORD_W-1:0]   top_n, word_n;

  // Length latch: zero or out-of-range requests return the full digest.
  always_comb begin
    len = CNT_W'(hash_num);
    if (hash_num == 5'd0 || int'(hash_num) > NWORDS)
      len = CNT_W'(NWORDS);
  end

  // Next-state: flush beats rd_en, which beats digest capture.
  always_comb begin
    st_n  = st;
    sr_n  = sr;
    cnt_n = cnt;
    ovf_n = overflow;
    if (flush) begin
      st_n  = IDLE;
      sr_n  = '0;
      cnt_n = '0;
      ovf_n = 1'b0;
    end else if (st == SERVE) begin
      if (rd_en) begin
        if (cnt == CNT_W'(1)) begin
          st_n  = IDLE;
          sr_n  = '0;
          cnt_n = '0;
        end else begin
          sr_n  = sr << WORD_W;
          cnt_n = cnt - CNT_W'(1);
        end
      end
      // Still busy this cycle, even if the last word is leaving.
      if (digest_valid) ovf_n = 1'b1;
    end else if (digest_valid) begin
      st_n  = SERVE;
      sr_n  = digest_in;
      cnt_n = len;
    end
  end

  assign top_n = sr_n[DIGEST_W-1 -: WORD_W];

`ifdef KECCAK_BYTESWAP_EN
  // Byte reversal of the next output word, ahead of the output register.
  for (genvar b = 0; b < NBYTE; b++) begin : g_swap
    assign word_n[8*b +: 8] = top_n[WORD_W-8-8*b +: 8];
  end
`else
  assign word_n = top_n;
`endif

  // State and output registers; outputs derive from next state so they are
  // valid right after the capturing edge and free of combinational glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      overflow    <= 1'b0;
      hash_out32  <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      digest_busy <= 1'b0;
    end else begin
      st          <= st_n;
      sr          <= sr_n;
      cnt         <= cnt_n;
      overflow    <= ovf_n;
      hash_out32  <= (st_n == SERVE) ? word_n : '0;
      out_valid   <= (st_n == SERVE);
      out_last    <= (st_n == SERVE) && (cnt_n == CNT_W'(1));
      digest_busy <= (st_n == SERVE);
    end
  end

endmodule

// File: tb/tb_keccak_digest_reader.sv
// Directed self-checking bench for keccak_digest_reader.
module tb_keccak_digest_reader;
  localparam int DIGEST_W = 512;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = DIGEST_W / WORD_W;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:0]          hash_num;
  logic [DIGEST_W-1:0] digest_in;
  logic                digest_valid;
  logic                digest_busy;
  logic [WORD_W-1:0]   hash_out32;
  logic                out_valid;
  logic                out_last;
  logic                rd_en;
  logic                flush;
  logic                overflow;

  int errors = 0;
  int checks = 0;

  keccak_digest_reader #(.DIGEST_W(DIGEST_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .hash_num(hash_num), .digest_in(digest_in),
    .digest_valid(digest_valid), .digest_busy(digest_busy),
    .hash_out32(hash_out32), .out_valid(out_valid), .out_last(out_last),
    .rd_en(rd_en), .flush(flush), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Digest whose word i equals base+i.
  function automatic logic [DIGEST_W-1:0] mk_digest(input logic [31:0] base);
    logic [DIGEST_W-1:0] d;
    d = '0;
    for (int i = 0; i < NWORDS; i++) d[DIGEST_W-1-WORD_W*i -: WORD_W] = base + 32'(i);
    return d;
  endfunction

  // Advance one edge; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [4:0] hn, input logic [DIGEST_W-1:0] d);
    hash_num     = hn;
    digest_in    = d;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; hash_num = '0; digest_in = '0; digest_valid = 0;
    rd_en = 0; flush = 0;
    step(); step();
    checks++; if (hash_out32 !== 32'h0) begin errors++; $display("FAIL reset_hash_out32 got=%h exp=0", hash_out32); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (digest_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", digest_busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_len8();
    // rd_en in IDLE must do nothing
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_en got=%b exp=0", out_valid); end
    capture(5'd8, mk_digest(32'h0));
    checks++; if (out_valid !== 1'b1 || hash_out32 !== 32'h0) begin errors++; $display("FAIL len8_first got=%b/%h exp=1/0", out_valid, hash_out32); end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || hash_out32 !== 32'(i) || out_last !== (i == 7) || digest_busy !== 1'b1) begin
        errors++;
        $display("FAIL len8_word%0d got v=%b d=%h l=%b b=%b exp v=1 d=%h l=%b b=1", i, out_valid, hash_out32, out_last, digest_busy, 32'(i), (i == 7));
      end
      step();
    end
    rd_en = 1'b0;
    checks++; if (out_valid !== 1'b0 || digest_busy !== 1'b0 || hash_out32 !== 32'h0) begin errors++; $display("FAIL len8_done got v=%b b=%b d=%h exp 0/0/0", out_valid, digest_busy, hash_out32); end
  endtask

  task automatic test_len_clamp();
    logic [4:0] hns [2];
    int n, last_idx;
    hns[0] = 5'd0; hns[1] = 5'd20;
    for (int k = 0; k < 2; k++) begin
      capture(hns[k], mk_digest(32'h100 * (k + 1)));
      rd_en = 1'b1;
      n = 0; last_idx = -1;
      for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
        checks++;
        if (hash_out32 !== 32'h100 * (k + 1) + 32'(n)) begin errors++; $display("FAIL clamp%0d_word%0d got=%h exp=%h", hns[k], n, hash_out32, 32'h100 * (k + 1) + 32'(n)); end
        if (out_last === 1'b1) last_idx = n;
        n++;
        step();
      end
      rd_en = 1'b0;
      checks++; if (n != NWORDS) begin errors++; $display("FAIL clamp%0d_count got=%0d exp=%0d", hns[k], n, NWORDS); end
      checks++; if (last_idx != NWORDS - 1) begin errors++; $display("FAIL clamp%0d_last got=%0d exp=%0d", hns[k], last_idx, NWORDS - 1); end
    end
  endtask

  task automatic test_stall();
    logic pat [6];
    int idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    capture(5'd4, mk_digest(32'hA0));
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b1 || hash_out32 !== 32'hA0 + 32'(idx)) begin errors++; $display("FAIL stall_c%0d got v=%b d=%h exp v=1 d=%h", c, out_valid, hash_out32, 32'hA0 + 32'(idx)); end
      rd_en = pat[c];
      step();
      if (pat[c]) idx++;
    end
    // idx now 3: last word remains
    checks++; if (out_last !== 1'b1 || hash_out32 !== 32'hA3) begin errors++; $display("FAIL stall_last got l=%b d=%h exp l=1 d=000000a3", out_last, hash_out32); end
    // last word consumed with a new digest in the same cycle: dropped, overflow
    rd_en = 1'b1;
    capture(5'd2, mk_digest(32'hB0));
    rd_en = 1'b0;
    checks++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL last_plus_valid got v=%b o=%b exp v=0 o=1", out_valid, overflow); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL last_plus_flush got o=%b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    capture(5'd8, mk_digest(32'hC0));
    capture(5'd3, mk_digest(32'hD0));
    checks++; if (overflow !== 1'b1 || hash_out32 !== 32'hC0) begin errors++; $display("FAIL ovf_set got o=%b d=%h exp o=1 d=000000c0", overflow, hash_out32); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (overflow !== 1'b1 || hash_out32 !== 32'hC1 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_sticky got o=%b d=%h v=%b exp o=1 d=000000c1 v=1", overflow, hash_out32, out_valid); end
    // flush wins over rd_en
    flush = 1'b1; rd_en = 1'b1; step(); flush = 1'b0; rd_en = 1'b0;
    checks++; if (out_valid !== 1'b0 || overflow !== 1'b0 || digest_busy !== 1'b0 || hash_out32 !== 32'h0) begin errors++; $display("FAIL ovf_flush got v=%b o=%b b=%b d=%h exp 0/0/0/0", out_valid, overflow, digest_busy, hash_out32); end
    // flush together with digest_valid in IDLE discards the digest
    flush = 1'b1; capture(5'd4, mk_digest(32'hE0)); flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_capture got v=%b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    capture(5'd8, mk_digest(32'h200));
    rd_en = 1'b1; step(); step(); step(); rd_en = 1'b0;
    checks++; if (hash_out32 !== 32'h203) begin errors++; $display("FAIL arst_pre got=%h exp=00000203", hash_out32); end
    #2 rst = 1'b0;
    #1;
    checks++; if (hash_out32 !== 32'h0 || out_valid !== 1'b0 || out_last !== 1'b0 || digest_busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL arst_now got d=%h v=%b l=%b b=%b o=%b exp all 0", hash_out32, out_valid, out_last, digest_busy, overflow); end
    step(); rst = 1'b1; step();
    capture(5'd2, mk_digest(32'h300));
    checks++; if (out_valid !== 1'b1 || hash_out32 !== 32'h300 || out_last !== 1'b0) begin errors++; $display("FAIL arst_fresh got v=%b d=%h l=%b exp 1/00000300/0", out_valid, hash_out32, out_last); end
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_byteswap();
    logic [DIGEST_W-1:0] d;
    logic [31:0] exp_w;
    d = '0;
    d[DIGEST_W-1 -: WORD_W] = 32'h11223344;
`ifdef KECCAK_BYTESWAP_EN
    exp_w = 32'h44332211;
`else
    exp_w = 32'h11223344;
`endif
    capture(5'd1, d);
    checks++; if (hash_out32 !== exp_w || out_last !== 1'b1) begin errors++; $display("FAIL byteswap got d=%h l=%b exp d=%h l=1", hash_out32, out_last, exp_w); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL byteswap_done got v=%b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_len8();
    test_len_clamp();
    test_stall();
    test_overflow();
    test_async_reset();
    test_byteswap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
